// File: rtl/song_select_ctrl_pkg.sv
// rtl/song_select_ctrl_pkg.sv - shared types and defaults for the playback controller
//
// Purpose: state encoding, default parameters and the song-index wrap helper
// used by song_select_ctrl and its restart timer.

package song_select_ctrl_pkg;

  // Encodings are shared with the music_player top and its benches.
  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  localparam int DEF_NUM_SONGS    = 4;
  localparam int DEF_SONG_W       = 2;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int TIMER_W          = 4;

  // Next song index, wrapping at the album length rather than at 2^SONG_W.
  function automatic int wrap_inc(input int idx, input int num_songs);
    return (idx >= num_songs - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/song_select_ctrl_restart_timer.sv
// rtl/song_select_ctrl_restart_timer.sv - loadable down-counter timing the RESTART state
//
// Purpose: counts the cycles reset_player stays high after a song change.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         load load_val_i into the counter (takes priority over en_i)
//   load_val_i     initial count; done_o rises load_val_i cycles after the load
//   en_i           decrement enable (stops at zero)
//   done_o         counter is zero

module song_select_ctrl_restart_timer
  import song_select_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/song_select_ctrl.sv
// rtl/song_select_ctrl.sv - play/pause, song index and restart-pulse sequencer
//
// Purpose: owns the playback state of the music player datapath.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   play_button      pulse, toggles play/pause
//   next_button      pulse, advance to the next song
//   keypad_value     requested song index, qualified by keypad_valid
//   keypad_valid     pulse
//   song_done        pulse from the song reader at end of song
//   play             datapath advancing
//   song             current song index
//   reset_player     restart pulse to song reader / note player
//   busy             high while restarting

module song_select_ctrl
  import song_select_ctrl_pkg::*;
#(
  parameter int NUM_SONGS    = DEF_NUM_SONGS,
  parameter int SONG_W       = DEF_SONG_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic [3:0]        keypad_value,
  input  logic              keypad_valid,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic                resume_q, resume_d;
  logic                play_q;
  logic                restart_q;
  logic                timer_load;
  logic                timer_done;
  logic                keypad_ok;
  logic                song_is_last;
  logic [SONG_W-1:0]   song_inc;

  // Out-of-range keypad entries are treated as if no key was pressed.
  assign keypad_ok    = keypad_valid && (int'(keypad_value) < NUM_SONGS);
  assign song_is_last = (int'(song_q) == NUM_SONGS - 1);
  assign song_inc     = SONG_W'(wrap_inc(int'(song_q), NUM_SONGS));

  // Priority inside each branch: keypad > next > song_done > play_button.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    resume_d   = resume_q;
    timer_load = 1'b0;
    case (state_q)
      ST_PAUSED: begin
        if (keypad_ok) begin
          song_d     = keypad_value[SONG_W-1:0];
          resume_d   = 1'b0;
          state_d    = ST_RESTART;
          timer_load = 1'b1;
        end else if (next_button) begin
          song_d     = song_inc;
          resume_d   = 1'b0;
          state_d    = ST_RESTART;
          timer_load = 1'b1;
        end else if (play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (keypad_ok) begin
          song_d     = keypad_value[SONG_W-1:0];
          resume_d   = 1'b1;
          state_d    = ST_RESTART;
          timer_load = 1'b1;
        end else if (next_button) begin
          song_d     = song_inc;
          resume_d   = 1'b1;
          state_d    = ST_RESTART;
          timer_load = 1'b1;
        end else if (song_done) begin
          // Finishing the last song of the album stops playback.
          song_d     = song_inc;
          resume_d   = !song_is_last;
          state_d    = ST_RESTART;
          timer_load = 1'b1;
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_RESTART: begin
        if (timer_done) begin
          state_d = resume_q ? ST_PLAYING : ST_PAUSED;
        end
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PAUSED;
      song_q    <= '0;
      resume_q  <= 1'b0;
      play_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      song_q    <= song_d;
      resume_q  <= resume_d;
      play_q    <= (state_d == ST_PLAYING);
      restart_q <= (state_d == ST_RESTART);
    end
  end

  // Loaded with RESET_CYCLES-1 so RESTART lasts exactly RESET_CYCLES cycles
  // (the exit edge is the one on which the counter already reads zero).
  song_select_ctrl_restart_timer #(.W(TIMER_W)) u_restart_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (timer_load),
    .load_val_i (TIMER_W'(RESET_CYCLES - 1)),
    .en_i       (state_q == ST_RESTART),
    .done_o     (timer_done)
  );

  assign play         = play_q;
  assign song         = song_q;
  assign reset_player = restart_q;
  assign busy         = restart_q;

endmodule

// File: tb/tb_song_select_ctrl.sv
// tb/tb_song_select_ctrl.sv - self-checking bench for song_select_ctrl

module tb_song_select_ctrl;

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic [3:0] keypad_value;
  logic       keypad_valid;
  logic       song_done;

  logic       play0, rp0, busy0;
  logic [1:0] song0;
  logic       play1, rp1, busy1;
  logic [2:0] song1;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 0;

  song_select_ctrl dut0 (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .keypad_value (keypad_value),
    .keypad_valid (keypad_valid),
    .song_done    (song_done),
    .play         (play0),
    .song         (song0),
    .reset_player (rp0),
    .busy         (busy0)
  );

  song_select_ctrl #(.NUM_SONGS(6), .SONG_W(3), .RESET_CYCLES(2)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .keypad_value (keypad_value),
    .keypad_valid (keypad_valid),
    .song_done    (song_done),
    .play         (play1),
    .song         (song1),
    .reset_player (rp1),
    .busy         (busy1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: per instance, the playing flag, song, cycles of
  // restart remaining and whether to resume afterwards.
  int NS [2] = '{4, 6};
  int RC [2] = '{4, 2};
  int m_song [2];
  int m_left [2];
  bit m_play [2];
  bit m_res  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_song[k] = 0; m_left[k] = 0; m_play[k] = 0; m_res[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_play[k] = m_res[k];
      end else if (keypad_valid && int'(keypad_value) < NS[k]) begin
        m_song[k] = int'(keypad_value);
        m_res[k] = m_play[k]; m_play[k] = 0; m_left[k] = RC[k];
      end else if (next_button) begin
        m_song[k] = (m_song[k] + 1) % NS[k];
        m_res[k] = m_play[k]; m_play[k] = 0; m_left[k] = RC[k];
      end else if (song_done && m_play[k]) begin
        m_res[k] = (m_song[k] != NS[k] - 1);
        m_song[k] = (m_song[k] + 1) % NS[k];
        m_play[k] = 0; m_left[k] = RC[k];
      end else if (play_button) begin
        m_play[k] = !m_play[k];
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("cyc_play0",  int'(play0), int'(m_play[0]));
      check("cyc_song0",  int'(song0), m_song[0]);
      check("cyc_rp0",    int'(rp0),   int'(m_left[0] > 0));
      check("cyc_busy0",  int'(busy0), int'(m_left[0] > 0));
      check("cyc_play1",  int'(play1), int'(m_play[1]));
      check("cyc_song1",  int'(song1), m_song[1]);
      check("cyc_rp1",    int'(rp1),   int'(m_left[1] > 0));
      check("cyc_busy1",  int'(busy1), int'(m_left[1] > 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    play_button = 0; next_button = 0; keypad_valid = 0; song_done = 0;
  endtask

  task automatic press_key(input int v);
    keypad_value = 4'(v); keypad_valid = 1; step(); clear_inputs();
  endtask

  task automatic press_play();
    play_button = 1; step(); clear_inputs();
  endtask

  task automatic press_next();
    next_button = 1; step(); clear_inputs();
  endtask

  task automatic pulse_done();
    song_done = 1; step(); clear_inputs();
  endtask

  initial begin
    reset = 1;
    keypad_value = 0;
    clear_inputs();
    repeat (3) step();
    reset = 0;
    cmp_en = 1;
    check("rst_play", int'(play0), 0);
    check("rst_song", int'(song0), 0);
    check("rst_rp",   int'(rp0),   0);
    check("rst_busy", int'(busy0), 0);

    repeat (3) step();
    press_play();
    check("play_on", int'(play0), 1);
    check("play_on_rp", int'(rp0), 0);

    press_key(3);
    repeat (4) step();
    check("kp3_playing", int'(play0), 1);
    check("kp3_song", int'(song0), 3);

    // next from the last song wraps to 0 and keeps playing
    press_next();
    check("next_wrap_song", int'(song0), 0);
    check("next_rp_n1", int'(rp0), 1);
    check("next_play_n1", int'(play0), 0);
    repeat (3) step();
    check("next_rp_n4", int'(rp0), 1);
    step();
    check("next_rp_n5", int'(rp0), 0);
    check("next_play_n5", int'(play0), 1);
    check("model_song_pin", m_song[0], 0);

    press_play();
    check("paused", int'(play0), 0);
    pulse_done();
    check("done_paused_busy", int'(busy0), 0);

    press_key(2);
    check("kp2_song", int'(song0), 2);
    check("kp2_rp", int'(rp0), 1);
    repeat (4) step();
    check("kp2_rp_end", int'(rp0), 0);
    check("kp2_still_paused", int'(play0), 0);

    press_key(9);
    check("kp9_song", int'(song0), 2);
    check("kp9_busy", int'(busy0), 0);

    // end-of-album stop
    press_play();
    press_key(3);
    repeat (4) step();
    pulse_done();
    check("album_end_song", int'(song0), 0);
    repeat (4) step();
    check("album_end_paused", int'(play0), 0);
    check("album_end_rp", int'(rp0), 0);

    // song_done mid-album keeps playing
    press_key(1);
    repeat (4) step();
    press_play();
    pulse_done();
    check("done_song2", int'(song0), 2);
    repeat (4) step();
    check("done_playing", int'(play0), 1);

    // same-cycle priority, then inputs ignored while restarting
    keypad_value = 4'd1; keypad_valid = 1; next_button = 1; play_button = 1;
    step(); clear_inputs();
    check("prio_song", int'(song0), 1);
    keypad_value = 4'd3; keypad_valid = 1; next_button = 1; play_button = 1; song_done = 1;
    step(); step(); clear_inputs();
    check("restart_ignore_song", int'(song0), 1);
    check("restart_ignore_rp", int'(rp0), 1);
    step(); step();
    check("prio_play", int'(play0), 1);
    check("prio_song_end", int'(song0), 1);

    // async reset two cycles into RESTART
    press_key(3);
    step();
    #1 reset = 1;
    #1;
    check("arst_rp",   int'(rp0),   0);
    check("arst_busy", int'(busy0), 0);
    check("arst_play", int'(play0), 0);
    check("arst_song", int'(song0), 0);
    check("arst_model_song", m_song[0], 0);
    step();
    reset = 0;
    step();
    check("arst_after_busy", int'(busy0), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1; step(); reset = 0;
      end else begin
        keypad_valid = ($urandom_range(0, 11) == 0);
        keypad_value = 4'($urandom_range(0, 15));
        next_button  = ($urandom_range(0, 14) == 0);
        song_done    = ($urandom_range(0, 5) == 0);
        play_button  = ($urandom_range(0, 7) == 0);
        if (keypad_valid && keypad_value >= 4'd4) begin
          next_button = 0; song_done = 0; play_button = 0;
        end
        step();
      end
    end
    clear_inputs();
    step();
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
